// File: rtl/cnt_debounce_demux.sv
// Free-running counter, 1-to-N registered demux and a symmetric input debouncer, all independent.
// Every output is registered with one cycle of latency, and the block never applies backpressure.
module cnt_debounce_demux #(
    parameter int N    = 4,
    parameter int DB_N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cnt_en,
    output logic [N-1:0]         cnt_count,
    input  logic                 dmx_data_i,
    input  logic [$clog2(N)-1:0] dmx_sel_i,
    output logic [N-1:0]         dmx_data_o,
    input  logic                 db_sig_i,
    output logic                 db_sig_o
);

    localparam int            CW      = $clog2(DB_N) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_N - 1);

    logic [CW-1:0] db_cnt;
    logic [N-1:0]  dmx_next;

    // Counter: natural wrap of the N-bit adder gives the modulo-2^N behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_count <= '0;
        end else if (cnt_en) begin
            cnt_count <= cnt_count + N'(1);
        end
    end

    // Demux: every bit is rewritten each cycle, so a deselected position clears on the same edge.
    always_comb begin
        dmx_next            = '0;
        dmx_next[dmx_sel_i] = dmx_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmx_data_o <= '0;
        end else begin
            dmx_data_o <= dmx_next;
        end
    end

    // Debounce: the output flips on the DB_N-th consecutive mismatching edge; any match restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt   <= '0;
            db_sig_o <= 1'b0;
        end else if (db_sig_i == db_sig_o) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_sig_o <= db_sig_i;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_cnt_debounce_demux.sv
`timescale 1ns/100ps
// Directed scenarios plus randomized traffic checked against a run-length reference model.
module tb_cnt_debounce_demux;

    localparam int N    = 4;
    localparam int DB_N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cnt_en;
    logic [N-1:0]         cnt_count;
    logic                 dmx_data_i;
    logic [$clog2(N)-1:0] dmx_sel_i;
    logic [N-1:0]         dmx_data_o;
    logic                 db_sig_i;
    logic                 db_sig_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt = 0;
    int m_dmx = 0;
    int m_db  = 0;
    int m_run = 0;

    cnt_debounce_demux #(.N(N), .DB_N(DB_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_en     (cnt_en),
        .cnt_count  (cnt_count),
        .dmx_data_i (dmx_data_i),
        .dmx_sel_i  (dmx_sel_i),
        .dmx_data_o (dmx_data_o),
        .db_sig_i   (db_sig_i),
        .db_sig_o   (db_sig_o)
    );

    always #2.5 clk = ~clk;

    task automatic model_reset;
        m_cnt = 0;
        m_dmx = 0;
        m_db  = 0;
        m_run = 0;
    endtask

    // Advance one rising edge, update the model from the inputs sampled there, then settle 1 ns.
    task automatic tick;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (cnt_en) m_cnt = (m_cnt + 1) % (1 << N);
            m_dmx = dmx_data_i ? (1 << dmx_sel_i) : 0;
            if (int'(db_sig_i) != m_db) begin
                m_run = m_run + 1;
                if (m_run == DB_N) begin
                    m_db  = int'(db_sig_i);
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; cnt_en = 1'b1; dmx_data_i = 1'b1; dmx_sel_i = 2; db_sig_i = 1'b1;
        tick(); tick();
        checks++;
        if (cnt_count !== 0 || dmx_data_o !== 0 || db_sig_o !== 1'b0 || dut.db_cnt !== 0) begin
            errors++;
            $display("FAIL reset: cnt=%0d dmx=%b db=%b db_cnt=%0d, required all 0",
                     cnt_count, dmx_data_o, db_sig_o, dut.db_cnt);
        end
        cnt_en = 1'b0; dmx_data_i = 1'b0; dmx_sel_i = 0; db_sig_i = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_counter_wrap;
        cnt_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            checks++;
            if (cnt_count !== N'(i % 16)) begin
                errors++;
                $display("FAIL counter_wrap edge %0d: got %0d, required %0d", i, cnt_count, i % 16);
            end
        end
    endtask

    task automatic test_counter_hold;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (cnt_count !== 4'd5) begin
            errors++;
            $display("FAIL counter_pre_hold: got %0d, required 5", cnt_count);
        end
        cnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cnt_count !== 4'd5) begin
                errors++;
                $display("FAIL counter_hold edge %0d: got %0d, required 5", i, cnt_count);
            end
        end
        cnt_en = 1'b1;
        tick();
        checks++;
        if (cnt_count !== 4'd6) begin
            errors++;
            $display("FAIL counter_resume: got %0d, required 6", cnt_count);
        end
        cnt_en = 1'b0;
    endtask

    task automatic test_demux_select;
        logic [N-1:0] exp_tbl [3];
        int           sel_tbl [3];
        sel_tbl[0] = 0; sel_tbl[1] = 1; sel_tbl[2] = 3;
        exp_tbl[0] = 4'b0001; exp_tbl[1] = 4'b0010; exp_tbl[2] = 4'b1000;
        dmx_data_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmx_sel_i = sel_tbl[i][1:0];
            #0.5;
            if (i > 0) begin
                checks++;
                if (dmx_data_o !== exp_tbl[i-1]) begin
                    errors++;
                    $display("FAIL demux_latency step %0d: got %b before edge, required %b",
                             i, dmx_data_o, exp_tbl[i-1]);
                end
            end
            tick();
            checks++;
            if (dmx_data_o !== exp_tbl[i]) begin
                errors++;
                $display("FAIL demux_select sel=%0d: got %b, required %b", sel_tbl[i], dmx_data_o, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_demux_zero;
        dmx_data_i = 1'b0;
        tick();
        checks++;
        if (dmx_data_o !== 4'b0000) begin
            errors++;
            $display("FAIL demux_zero: got %b, required 0000", dmx_data_o);
        end
    endtask

    task automatic test_db_rise;
        db_sig_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (db_sig_o !== (k >= DB_N)) begin
                errors++;
                $display("FAIL db_rise edge %0d: got %b, required %b", k, db_sig_o, k >= DB_N);
            end
        end
    endtask

    task automatic test_db_fall;
        db_sig_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (db_sig_o !== (k < DB_N)) begin
                errors++;
                $display("FAIL db_fall edge %0d: got %b, required %b", k, db_sig_o, k < DB_N);
            end
        end
    endtask

    task automatic test_db_glitch;
        logic [6:0] pattern;
        pattern = 7'b1110111;
        for (int k = 0; k < 7; k++) begin
            db_sig_i = pattern[6-k];
            tick();
            checks++;
            if (db_sig_o !== 1'b0) begin
                errors++;
                $display("FAIL db_glitch edge %0d: got %b, required 0", k, db_sig_o);
            end
        end
        db_sig_i = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        int guard;
        guard = 0;
        cnt_en = 1'b1;
        while (m_cnt != 9 - 1 && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        cnt_en = 1'b0; dmx_data_i = 1'b1; dmx_sel_i = 2; db_sig_i = 1'b1;
        tick(); tick();
        checks++;
        if (cnt_count !== 4'd9 || dmx_data_o !== 4'b0100 || db_sig_o !== 1'b0 || dut.db_cnt !== 2) begin
            errors++;
            $display("FAIL async_pre: cnt=%0d dmx=%b db=%b db_cnt=%0d, required 9 0100 0 2",
                     cnt_count, dmx_data_o, db_sig_o, dut.db_cnt);
        end
        #0.5 rst = 1'b0;
        #0.3;
        checks++;
        if (cnt_count !== 0 || dmx_data_o !== 0 || db_sig_o !== 1'b0 || dut.db_cnt !== 0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d dmx=%b db=%b db_cnt=%0d, required all 0 before edge",
                     cnt_count, dmx_data_o, db_sig_o, dut.db_cnt);
        end
        model_reset();
        tick();
        #0.2 rst = 1'b1; cnt_en = 1'b1; dmx_data_i = 1'b0;
    endtask

    task automatic test_restart;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (db_sig_o !== (k >= DB_N)) begin
                errors++;
                $display("FAIL restart_db edge %0d: got %b, required %b", k, db_sig_o, k >= DB_N);
            end
            if (k == 1) begin
                checks++;
                if (cnt_count !== 4'd1) begin
                    errors++;
                    $display("FAIL restart_cnt: got %0d, required 1", cnt_count);
                end
            end
        end
    endtask

    task automatic test_random;
        int hold;
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            cnt_en     = 1'($urandom_range(0, 3) != 0);
            dmx_data_i = 1'($urandom);
            dmx_sel_i  = 2'($urandom);
            if (hold == 0) begin
                db_sig_i = 1'($urandom);
                hold     = $urandom_range(1, 6);
            end
            hold--;
            rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (cnt_count !== N'(m_cnt) || dmx_data_o !== N'(m_dmx) || int'(db_sig_o) != m_db) begin
                errors++;
                $display("FAIL random cycle %0d: cnt=%0d dmx=%b db=%b, required cnt=%0d dmx=%b db=%0d",
                         c, cnt_count, dmx_data_o, db_sig_o, m_cnt, N'(m_dmx), m_db);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_counter_wrap();
        test_counter_hold();
        test_demux_select();
        test_demux_zero();
        test_db_rise();
        test_db_fall();
        test_db_glitch();
        test_async_reset();
        test_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_debounce_demux.md
CNT_DEBOUNCE_DEMUX -- requirements
Module: cnt_debounce_demux

Interface
REQ-001 Parameter N, default 4: counter width and demux output width; N SHALL be a power of two and at least 2.
REQ-002 Parameter DB_N, default 4: debounce qualification length in clock cycles; DB_N SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cnt_en  input  1  counter enable.
REQ-006 cnt_count  output  N  counter value, registered.
REQ-007 dmx_data_i  input  1  demux data bit.
REQ-008 dmx_sel_i  input  $clog2(N)  demux output select.
REQ-009 dmx_data_o  output  N  demux outputs, registered.
REQ-010 db_sig_i  input  1  raw (bouncing) input, synchronous to clk.
REQ-011 db_sig_o  output  1  debounced output, registered.
REQ-012 All three sub-functions SHALL be independent, with no signal shared between them other than clk and rst.

Function -- counter
REQ-013 On each rising edge with cnt_en=1, cnt_count SHALL increment by 1 modulo 2^N.
REQ-014 The counter SHALL wrap from 2^N-1 to 0 in a single cycle, with no sticky or terminal flag.
REQ-015 With cnt_en=0, cnt_count SHALL hold its value.
REQ-016 The first increment SHALL appear on the first rising edge that samples cnt_en=1, so latency is one cycle.

Function -- demux
REQ-017 On each rising edge, dmx_data_o[dmx_sel_i] SHALL load dmx_data_i and every other bit SHALL load 0.
REQ-018 Latency from input to output SHALL be exactly one cycle.
REQ-019 A change of dmx_sel_i SHALL move the bit to the new position on the next edge and clear the old position on that same edge.
REQ-020 No output bit SHALL ever be set other than the selected bit.

Function -- debounce
REQ-021 An internal counter db_cnt of width $clog2(DB_N)+1 SHALL track consecutive mismatches.
REQ-022 On each edge where db_sig_i equals db_sig_o, db_cnt SHALL clear to 0.
REQ-023 On each edge where db_sig_i differs from db_sig_o and db_cnt < DB_N-1, db_cnt SHALL increment.
REQ-024 On each edge where db_sig_i differs from db_sig_o and db_cnt = DB_N-1, db_sig_o SHALL load db_sig_i and db_cnt SHALL clear.
REQ-025 db_sig_o SHALL therefore change only after DB_N consecutive sampled edges of mismatch, and SHALL change on the DB_N-th such edge.
REQ-026 Any single-cycle return to the current db_sig_o level SHALL restart qualification from zero.
REQ-027 Rising and falling transitions SHALL be qualified symmetrically.
REQ-028 With DB_N=1, db_sig_o SHALL follow db_sig_i with one-cycle latency.

Reset
REQ-029 While rst=0, the block SHALL hold cnt_count=0, dmx_data_o=0, db_sig_o=0 and db_cnt=0, asynchronously and independent of clk.
REQ-030 Reset asserted mid-count or mid-qualification SHALL discard the count or the partial qualification immediately.
REQ-031 After rst rises, each function SHALL resume normal operation on the first rising edge, with no extra wait states.

Verification
REQ-032 Counter count and wrap: rst released, cnt_en=1 held for 17 edges (N=4) -> cnt_count runs 1..15, then 0, then 1.
REQ-033 Counter hold: set cnt_en=0 at cnt_count=5 for 3 edges -> cnt_count stays 5, then resumes at 6.
REQ-034 Demux select: dmx_data_i=1 with dmx_sel_i=0,1,3 on successive cycles -> dmx_data_o = 0001, 0010, 1000, each one cycle after its input.
REQ-035 Demux zero input: set dmx_data_i=0 -> dmx_data_o=0000 on the next edge.
REQ-036 Debounce rising, clean: db_sig_i=1 held for 40 ns (8 edges, DB_N=4) -> db_sig_o rises on the 4th edge.
REQ-037 Debounce glitch rejection: db_sig_i high 3 edges, low 1 edge, high 3 edges -> db_sig_o stays 0.
REQ-038 Debounce falling: from db_sig_o=1, db_sig_i=0 held -> db_sig_o falls on the 4th edge.
REQ-039 Asynchronous reset: pull rst low between edges while cnt_count=9 and db_cnt=2 -> all outputs 0 immediately, before the next edge.
REQ-040 Restart after reset: after the reset in REQ-039, a fresh 4-edge qualification is required to move db_sig_o.
